multi_counter_mon: RTL and testbench
====================================

// Module: multi_counter_mon
// PURPOSE
//   Parametrised bank of N_CH independent up-counters with terminal-value monitoring.
//   Each channel has its own enable and synchronous clear, and runs in wrap or saturate mode.
//   Any channel at TERM drives a combinational err. A registered sticky error also latches
//   the lowest-index offending channel.
//   Sits beside datapath event sources as a formal/perf target and as a runtime overflow watchdog.
// PARAMETERS
//   N_CH     2        number of counter channels (>=1)
//   WIDTH    12       counter width in bits (>=2)
//   TERM     {WIDTH{1'b1}}  terminal value compared against every channel
//   SATURATE 0        0: wrap modulo 2^WIDTH; 1: hold at all-ones once reached
//   IDX_W    (N_CH>1 ? $clog2(N_CH) : 1)  width of err_first (derived, do not override)
// PORTS
//   clk        in   1             rising-edge clock
//   rst        in   1             asynchronous reset, active-high
//   ena        in   N_CH          per-channel increment enable
//   clr        in   N_CH          per-channel synchronous clear to 0
//   err_clr    in   1             clears err_sticky / err_first
//   count      out  N_CH*WIDTH    channel i at count[i*WIDTH +: WIDTH], registered
//   hit        out  N_CH          hit[i] = (count_i == TERM), combinational from registers
//   err        out  1             |hit, combinational
//   err_sticky out  1             registered, set after any hit, held until err_clr
//   err_first  out  IDX_W         lowest channel index with hit when err_sticky was set
// BEHAVIOUR
//   Clock/reset: one clock; reset is asynchronous and active-high.
//   rst=1 forces all count=0, err_sticky=0 and err_first=0 immediately, with no clock edge.
//     hit=0 and err=0 also follow while rst is held, unless TERM==0.
//   Per-channel update on each posedge clk, with priority clr > ena > hold:
//     clr[i]=1              -> count_i <= 0, regardless of ena[i].
//     ena[i]=1, SATURATE=0  -> count_i <= count_i+1 mod 2^WIDTH; all-ones wraps to 0.
//     ena[i]=1, SATURATE=1  -> count_i <= count_i+1 if below all-ones, else holds all-ones.
//     otherwise             -> hold.
//   Latency: a count change is visible 1 cycle after the qualifying edge.
//     hit and err follow count in the same cycle, with no extra delay.
//     err_sticky rises on the edge after the first cycle in which err=1.
//   Channels are fully independent; simultaneous ena on all channels is legal.
//   Sticky error, evaluated at each posedge:
//     err=1 and err_sticky=0   -> err_sticky<=1; err_first <= lowest i with hit[i]=1.
//     err=1 and err_sticky=1   -> err_first holds; the first event wins.
//     err_clr=1 and err=0      -> err_sticky<=0, err_first<=0.
//     err_clr=1 and err=1      -> set wins: err_sticky stays/becomes 1.
//       err_first is reloaded with the current lowest hit index.
//   Wrap mode with TERM=all-ones: hit lasts exactly one cycle per wrap when ena is held.
//   Saturate mode: hit stays high until clr[i].
//   TERM==0: hit is asserted out of reset; err_sticky sets on the first edge after rst drops.
//   Reset mid-count: all state returns to reset values immediately; no partial update survives.
//   No X on outputs after reset, for any ena/clr/err_clr combination.
// TESTING
//   T1 N_CH=2,W=12: rst pulse, ena=2'b01 for 4095 cycles
//      -> count0=0xFFF, hit=01, err=1; err_sticky=1 and err_first=0 next edge; count1=0.
//   T2 wrap: T1 state, one more ena0 -> count0=0x000, hit0=0, err=0; err_sticky stays 1.
//   T3 SATURATE=1: ena0 held 5000 cycles -> count0 stays 0xFFF, hit0 stays 1.
//      clr0=1 with ena0=1 -> count0=0 next cycle.
//   T4 simultaneous: preload count1=0xFFE and count0=0xFFE, then ena=2'b11 for one cycle
//      -> hit=11; err_first=0 (lowest index); then err_clr=1 while err=1
//      -> err_sticky remains 1.
//   T5 err_clr: with err=0 and err_sticky=1, pulse err_clr -> err_sticky=0, err_first=0 next edge.
//   T6 async reset: assert rst mid-cycle with count0=0x123
//      -> count0=0 and err_sticky=0 before the next clk edge; release -> counting resumes from 0.

Source files
------------

// File: rtl/multi_counter_mon.sv
// multi_counter_mon: bank of independent up-counters with terminal-value hit detection
// and a sticky error that records the lowest-index channel of the first hit.
module multi_counter_mon #(
    parameter int               N_CH     = 2,
    parameter int               WIDTH    = 12,
    parameter logic [WIDTH-1:0] TERM     = {WIDTH{1'b1}},
    parameter bit               SATURATE = 1'b0,
    parameter int               IDX_W    = (N_CH > 1) ? $clog2(N_CH) : 1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [N_CH-1:0]       ena,
    input  logic [N_CH-1:0]       clr,
    input  logic                  err_clr,
    output logic [N_CH*WIDTH-1:0] count,
    output logic [N_CH-1:0]       hit,
    output logic                  err,
    output logic                  err_sticky,
    output logic [IDX_W-1:0]      err_first
);
    localparam logic [WIDTH-1:0] ONES = {WIDTH{1'b1}};
    logic [IDX_W-1:0] w_first;
    logic             r_sticky;
    logic [IDX_W-1:0] r_first;
    for (genvar i = 0; i < N_CH; i++) begin : g_ch
        logic [WIDTH-1:0] r_cnt;
        always_ff @(posedge clk or posedge rst)
            if (rst)
                r_cnt <= '0;
            else if (clr[i])
                r_cnt <= '0;
            else if (ena[i])
                r_cnt <= (SATURATE && r_cnt == ONES) ? r_cnt : r_cnt + WIDTH'(1);
        assign count[i*WIDTH +: WIDTH] = r_cnt;
        assign hit[i] = (r_cnt == TERM);
    end
    assign err = |hit;
    // scan downward so the lowest hitting index is the one left standing
    always_comb begin
        w_first = '0;
        for (int k = N_CH - 1; k >= 0; k--)
            if (hit[k]) w_first = IDX_W'(k);
    end
    // a new hit always beats err_clr; err_first only reloads on a fresh set or a clear attempt
    always_ff @(posedge clk or posedge rst)
        if (rst) begin
            r_sticky <= 1'b0;
            r_first  <= '0;
        end else if (err) begin
            r_sticky <= 1'b1;
            if (!r_sticky || err_clr) r_first <= w_first;
        end else if (err_clr) begin
            r_sticky <= 1'b0;
            r_first  <= '0;
        end
    assign err_sticky = r_sticky;
    assign err_first  = r_first;
endmodule

// File: tb/tb_multi_counter_mon.sv
// tb_multi_counter_mon: directed checks of wrap and saturate instances against
// hand-computed counts, hit/err flags and sticky error behaviour.
module tb_multi_counter_mon;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [1:0]  ena = '0, clr = '0;
    logic        err_clr = 1'b0;
    logic [23:0] count;
    logic [1:0]  hit;
    logic        err, err_sticky;
    logic [0:0]  err_first;
    logic [1:0]  s_ena = '0, s_clr = '0;
    logic        s_err_clr = 1'b0;
    logic [23:0] s_count;
    logic [1:0]  s_hit;
    logic        s_err, s_err_sticky;
    logic [0:0]  s_err_first;
    int          total = 0, bad = 0;
    always #5 clk = ~clk;
    multi_counter_mon #(.N_CH(2), .WIDTH(12), .SATURATE(1'b0)) u_wrap (
        .clk(clk), .rst(rst), .ena(ena), .clr(clr), .err_clr(err_clr),
        .count(count), .hit(hit), .err(err), .err_sticky(err_sticky), .err_first(err_first)
    );
    multi_counter_mon #(.N_CH(2), .WIDTH(12), .SATURATE(1'b1)) u_sat (
        .clk(clk), .rst(rst), .ena(s_ena), .clr(s_clr), .err_clr(s_err_clr),
        .count(s_count), .hit(s_hit), .err(s_err), .err_sticky(s_err_sticky), .err_first(s_err_first)
    );
    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
        end
    endtask
    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask
    initial begin
        #2;
        chk("rst_count", count, 0);
        chk("rst_hit", hit, 0);
        chk("rst_err", err, 0);
        chk("rst_sticky", err_sticky, 0);
        #10 rst = 1'b0;
        ena = 2'b01;
        step(4095);
        chk("t1_count0", count[11:0], 12'hFFF);
        chk("t1_hit", hit, 2'b01);
        chk("t1_err", err, 1);
        chk("t1_sticky_late", err_sticky, 0);
        ena = 2'b00;
        step(1);
        chk("t1_sticky", err_sticky, 1);
        chk("t1_first", err_first, 0);
        chk("t1_count1", count[23:12], 0);
        chk("t1_hold", count[11:0], 12'hFFF);
        ena = 2'b01;
        step(1);
        chk("t2_wrap", count[11:0], 0);
        chk("t2_hit", hit, 0);
        chk("t2_err", err, 0);
        chk("t2_sticky", err_sticky, 1);
        ena = 2'b00;
        err_clr = 1'b1;
        step(1);
        err_clr = 1'b0;
        chk("t5_sticky", err_sticky, 0);
        chk("t5_first", err_first, 0);
        ena = 2'b10;
        step(4095);
        chk("ch1_hit", hit, 2'b10);
        ena = 2'b00;
        step(1);
        chk("ch1_sticky", err_sticky, 1);
        chk("ch1_first", err_first, 1);
        clr = 2'b11;
        ena = 2'b11;
        step(1);
        clr = 2'b00;
        chk("clr_prio", count, 0);
        ena = 2'b00;
        err_clr = 1'b1;
        step(1);
        err_clr = 1'b0;
        chk("t4_pre_sticky", err_sticky, 0);
        ena = 2'b11;
        step(4094);
        chk("t4_preload", count, 24'hFFEFFE);
        chk("t4_pre_hit", hit, 0);
        step(1);
        chk("t4_hit", hit, 2'b11);
        ena = 2'b00;
        step(1);
        chk("t4_first", err_first, 0);
        chk("t4_sticky", err_sticky, 1);
        err_clr = 1'b1;
        step(1);
        err_clr = 1'b0;
        chk("t4_set_wins", err_sticky, 1);
        chk("t4_first_reload", err_first, 0);
        clr = 2'b11;
        step(1);
        clr = 2'b00;
        ena = 2'b01;
        step(12'h123);
        chk("t6_pre", count[11:0], 12'h123);
        chk("t6_pre_sticky", err_sticky, 1);
        #2 rst = 1'b1;
        #1;
        chk("t6_async_count", count, 0);
        chk("t6_async_sticky", err_sticky, 0);
        #1 rst = 1'b0;
        step(1);
        chk("t6_resume1", count[11:0], 1);
        step(1);
        chk("t6_resume2", count[11:0], 2);
        ena = 2'b00;
        s_ena = 2'b01;
        step(4095);
        chk("t3_reach", s_count[11:0], 12'hFFF);
        step(905);
        chk("t3_sat", s_count[11:0], 12'hFFF);
        chk("t3_hit", s_hit, 2'b01);
        chk("t3_count1", s_count[23:12], 0);
        s_clr = 2'b01;
        step(1);
        s_clr = 2'b00;
        s_ena = 2'b00;
        chk("t3_clr", s_count[11:0], 0);
        chk("t3_hit_clr", s_hit, 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
